btn_uart_arbiter: RTL
=====================

Name: btn_uart_arbiter

Overview:
Shares one UART transmitter among NUM_BTN debounced button-pulse sources.
- Latches each one-cycle button pulse as a pending request.
- Grants requests round-robin.
- For each grant, sequences the transmitter through a start/busy handshake to send one ASCII code per button, optionally followed by a newline.
- Sits between the button debouncers and the UART TX.

Parameters:
NUM_BTN, 4, number of button requesters (2..8)
CHAR_BASE, 8'h30, ASCII code sent for button i is CHAR_BASE + i (mod 256)
APPEND_NL, 1, when 1 send 8'h0A after each button code; when 0 send code only

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset
btn_pulse  input  NUM_BTN  one-cycle pulses from debouncers, bit i = button i
tx_busy  input  1  UART TX busy; high from cycle after tx_start until frame done
tx_start  output  1  one-cycle request to UART TX to send tx_data
tx_data  output  8  byte to transmit; stable from tx_start until tx_busy falls
pending  output  NUM_BTN  latched, not-yet-granted requests
drop_cnt  output  8  saturating count of pulses lost to an already-pending request

Behaviour:
Reset (reset=0, asynchronous):
- tx_start=0, tx_data=0, pending=0, drop_cnt=0.
- State=IDLE; rr pointer=NUM_BTN-1, so the first search starts at bit 0.
- Reset mid-transfer abandons the transfer immediately; no further tx_start until new requests arrive.

Request latching, per bit i, each cycle:
- pending[i]_next = (pending[i] & ~clr[i]) | btn_pulse[i], where clr is the one-hot grant.
- Simultaneous pulse and grant on the same bit: set wins. The bit stays pending and is served again later.
- btn_pulse[i]=1 while pending[i]=1 and not being cleared that cycle: pulse dropped, drop_cnt += 1, saturating at 255.
- Multiple pulses dropped in the same cycle increment drop_cnt once per dropped bit, still saturating.

Arbitration (combinational, used in IDLE only):
- Search pending starting at rr+1, wrapping at NUM_BTN-1 to 0; the first set bit is the grant.
- On grant: clear that pending bit, rr <= grant index, tx_data <= CHAR_BASE + index.

FSM states:
- IDLE: if pending != 0 and tx_busy == 0: grant and go to START_C. Otherwise stay.
- START_C: tx_start=1 for this cycle only; go to ACK_C.
- ACK_C: wait for tx_busy=1, then go to DONE_C.
- DONE_C: wait for tx_busy=0. Then, if APPEND_NL: tx_data <= 8'h0A and go to START_N; else go to IDLE.
- START_N: tx_start=1 for one cycle; go to ACK_N.
- ACK_N: wait for tx_busy=1, then go to DONE_N.
- DONE_N: wait for tx_busy=0, then go to IDLE.

Timing and handshake rules:
- tx_start is registered and never high in two consecutive cycles.
- tx_data changes only in IDLE-grant and DONE_C.
- Latency: pulse at cycle t with FSM idle and tx_busy=0 gives pending visible at t+1, grant at t+1, tx_start at t+2.
- After a transfer completes, the next grant can occur in the first IDLE cycle, so back-to-back transfers have one IDLE cycle between them.
- No timeout: if tx_busy never rises, the FSM waits in ACK_x indefinitely, and pending keeps accumulating.
- tx_busy high while in IDLE blocks granting; no start is issued into a busy transmitter.

Test Plan:
- Single pulse btn_pulse=4'b0100, tx_busy model 10 cycles -> tx_start at t+2 with tx_data=8'h32; then tx_start with tx_data=8'h0A; pending returns to 0.
- Simultaneous pulses 4'b1011 after reset -> bytes 0x30,0x0A,0x31,0x0A,0x33,0x0A in that order; rr ends at 3.
- Fairness: hold bits 0 and 3 continually re-pulsed -> grants alternate 0,3,0,3; neither served twice in a row.
- Drop: pulse bit 1 three times while bit 1 pending and FSM busy -> drop_cnt=3; only one 0x31 is sent. Force 300 drops -> drop_cnt saturates at 255.
- Set-wins: pulse bit 2 in the same cycle it is granted -> pending[2]=1 afterward; 0x32 is sent twice.
- Reset mid-transfer: assert reset=0 in ACK_C -> tx_start=0, pending=0, drop_cnt=0 immediately; after release, no tx_start without new pulses. With APPEND_NL=0, only the code byte is sent.

Source files
------------

// File: rtl/btn_uart_arbiter.sv
// ---------------------------------------------------------------------------
// btn_uart_arbiter
//
// Shares one UART transmitter among NUM_BTN debounced button sources.
// Each one-cycle button pulse is latched as a pending request. Requests are
// granted round-robin. For every grant the transmitter is walked through a
// start/busy handshake to send the button's ASCII code (CHAR_BASE + index),
// optionally followed by a newline byte.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   btn_pulse  in   [NUM_BTN] one-cycle pulses, bit i = button i
//   tx_busy    in   UART TX busy, high from the cycle after tx_start
//   tx_start   out  one-cycle send request to the UART TX (registered)
//   tx_data    out  [8] byte to send, held until tx_busy falls
//   pending    out  [NUM_BTN] latched requests not yet granted
//   drop_cnt   out  [8] saturating count of pulses lost to a pending request
// ---------------------------------------------------------------------------
module btn_uart_arbiter #(
    parameter int         NUM_BTN   = 4,
    parameter logic [7:0] CHAR_BASE = 8'h30,
    parameter bit         APPEND_NL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_pulse,
    input  logic               tx_busy,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic [NUM_BTN-1:0] pending,
    output logic [7:0]         drop_cnt
);

    localparam int IDX_W  = $clog2(NUM_BTN);
    // One extra bit so rr + offset can exceed NUM_BTN-1 before wrapping.
    localparam int CAND_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START_C = 3'd1,
        S_ACK_C   = 3'd2,
        S_DONE_C  = 3'd3,
        S_START_N = 3'd4,
        S_ACK_N   = 3'd5,
        S_DONE_N  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               grant_vld_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [CAND_W-1:0]  cand_s;
    logic               grant_fire_s;
    logic [NUM_BTN-1:0] clr_s;
    logic [NUM_BTN-1:0] drop_bits_s;
    logic [3:0]         drop_inc_s;
    logic [8:0]         drop_sum_s;

    // Round-robin search: first pending bit at rr+1, rr+2, ... wrapping.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            cand_s = {1'b0, rr_q} + CAND_W'(k + 1);
            cand_s = (cand_s >= CAND_W'(NUM_BTN)) ? (cand_s - CAND_W'(NUM_BTN)) : cand_s;
            if (!grant_vld_s && pending_q[cand_s[IDX_W-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s[IDX_W-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Never start into a busy transmitter, even if requests are waiting.
    assign grant_fire_s = (state_q == S_IDLE) && grant_vld_s && !tx_busy;
    assign clr_s        = grant_fire_s ? ({{(NUM_BTN-1){1'b0}}, 1'b1} << grant_idx_s)
                                       : {NUM_BTN{1'b0}};

    // Next-state logic for the transmit sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = grant_fire_s ? S_START_C : S_IDLE;
            S_START_C: state_d = S_ACK_C;
            S_ACK_C:   state_d = tx_busy ? S_DONE_C : S_ACK_C;
            S_DONE_C: begin
                if (!tx_busy) begin
                    state_d = APPEND_NL ? S_START_N : S_IDLE;
                end else begin
                    state_d = S_DONE_C;
                end
            end
            S_START_N: state_d = S_ACK_N;
            S_ACK_N:   state_d = tx_busy ? S_DONE_N : S_ACK_N;
            S_DONE_N:  state_d = tx_busy ? S_DONE_N : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, request latch and drop counter.
    always_comb begin
        // tx_start is high exactly while the FSM sits in a START state.
        tx_start_d = (state_d == S_START_C) || (state_d == S_START_N);
        tx_data_d  = tx_data_q;
        rr_d       = rr_q;
        if (grant_fire_s) begin
            tx_data_d = CHAR_BASE + 8'(grant_idx_s);
            rr_d      = grant_idx_s;
        end else if ((state_q == S_DONE_C) && !tx_busy && APPEND_NL) begin
            tx_data_d = 8'h0A;
            rr_d      = rr_q;
        end else begin
            tx_data_d = tx_data_q;
            rr_d      = rr_q;
        end

        // A pulse on a bit being granted this cycle re-arms it (set wins).
        pending_d   = (pending_q & ~clr_s) | btn_pulse;
        drop_bits_s = btn_pulse & pending_q & ~clr_s;
        drop_inc_s  = 4'd0;
        for (int i = 0; i < NUM_BTN; i++) begin
            drop_inc_s = drop_inc_s + {3'b000, drop_bits_s[i]};
        end
        drop_sum_s = {1'b0, drop_cnt_q} + {5'b00000, drop_inc_s};
        drop_cnt_d = (drop_sum_s > 9'd255) ? 8'hFF : drop_sum_s[7:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            rr_q       <= IDX_W'(NUM_BTN - 1);
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign pending  = pending_q;
    assign drop_cnt = drop_cnt_q;

endmodule
